// File: rtl/exec_pkg.sv
// ----------------------------------------------------------------------
// exec_pkg : opcode encodings and mul/div FSM states        rev 1.0
// ----------------------------------------------------------------------
`default_nettype none

package exec_pkg;

  localparam logic [2:0] c_alu_and  = 3'b000;
  localparam logic [2:0] c_alu_or   = 3'b001;
  localparam logic [2:0] c_alu_add  = 3'b010;
  localparam logic [2:0] c_alu_xor  = 3'b011;
  localparam logic [2:0] c_alu_nor  = 3'b100;
  localparam logic [2:0] c_alu_passb = 3'b101;
  localparam logic [2:0] c_alu_sub  = 3'b110;
  localparam logic [2:0] c_alu_slt  = 3'b111;

  localparam logic [1:0] c_sh_srl  = 2'b00;
  localparam logic [1:0] c_sh_sra  = 2'b01;
  localparam logic [1:0] c_sh_sll  = 2'b10;
  localparam logic [1:0] c_sh_rotr = 2'b11;

  localparam logic [2:0] c_md_none = 3'b000;
  localparam logic [2:0] c_md_mult = 3'b001;
  localparam logic [2:0] c_md_div  = 3'b010;
  localparam logic [2:0] c_md_mthi = 3'b011;
  localparam logic [2:0] c_md_mtlo = 3'b100;
  localparam logic [2:0] c_md_mfhi = 3'b101;
  localparam logic [2:0] c_md_mflo = 3'b110;

  localparam logic [2:0] c_wb_alu  = 3'b000;
  localparam logic [2:0] c_wb_pc   = 3'b001;
  localparam logic [2:0] c_wb_hilo = 3'b010;
  localparam logic [2:0] c_wb_imm  = 3'b011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } md_state_t;

  function automatic logic is_muldiv(input logic [2:0] op);
    return (op == c_md_mult) || (op == c_md_div);
  endfunction

endpackage

`default_nettype wire

// File: rtl/execute_md_if.sv
// ----------------------------------------------------------------------
// execute_md_if : ID/EX inputs and EX/MEM outputs of the EX stage  rev 1.0
// ----------------------------------------------------------------------
`default_nettype none

interface execute_md_if #(
  parameter int DATA_W  = 32,
  parameter int SHAMT_W = 5,
  parameter int REG_W   = 5
);
  logic               id_ex_selalushift;
  logic               id_ex_selimregb;
  logic               id_ex_selsarega;
  logic [2:0]         id_ex_aluop;
  logic               id_ex_unsig;
  logic [1:0]         id_ex_shiftop;
  logic [SHAMT_W-1:0] id_ex_shiftamt;
  logic [2:0]         id_ex_mdop;
  logic [DATA_W-1:0]  id_ex_rega;
  logic [DATA_W-1:0]  id_ex_regb;
  logic [DATA_W-1:0]  id_ex_imedext;
  logic [DATA_W-1:0]  id_ex_proximopc;
  logic [2:0]         id_ex_msm;
  logic [2:0]         id_ex_msl;
  logic               id_ex_readmem;
  logic               id_ex_writemem;
  logic               id_ex_mshw;
  logic               id_ex_lshw;
  logic [2:0]         id_ex_selwsource;
  logic [REG_W-1:0]   id_ex_regdest;
  logic               id_ex_writereg;
  logic               id_ex_writeov;

  logic               ex_if_stall;
  logic [DATA_W-1:0]  ex_fw_wbvalue;
  logic               ex_fw_writereg;
  logic [2:0]         ex_mem_msm;
  logic [2:0]         ex_mem_msl;
  logic               ex_mem_readmem;
  logic               ex_mem_writemem;
  logic               ex_mem_mshw;
  logic               ex_mem_lshw;
  logic [DATA_W-1:0]  ex_mem_regb;
  logic [2:0]         ex_mem_selwsource;
  logic [REG_W-1:0]   ex_mem_regdest;
  logic               ex_mem_writereg;
  logic [DATA_W-1:0]  ex_mem_aluout;
  logic [DATA_W-1:0]  ex_mem_wbvalue;
  logic               ex_mem_ovf;

  modport master (
    output id_ex_selalushift, id_ex_selimregb, id_ex_selsarega, id_ex_aluop,
           id_ex_unsig, id_ex_shiftop, id_ex_shiftamt, id_ex_mdop, id_ex_rega,
           id_ex_regb, id_ex_imedext, id_ex_proximopc, id_ex_msm, id_ex_msl,
           id_ex_readmem, id_ex_writemem, id_ex_mshw, id_ex_lshw,
           id_ex_selwsource, id_ex_regdest, id_ex_writereg, id_ex_writeov,
    input  ex_if_stall, ex_fw_wbvalue, ex_fw_writereg, ex_mem_msm, ex_mem_msl,
           ex_mem_readmem, ex_mem_writemem, ex_mem_mshw, ex_mem_lshw,
           ex_mem_regb, ex_mem_selwsource, ex_mem_regdest, ex_mem_writereg,
           ex_mem_aluout, ex_mem_wbvalue, ex_mem_ovf
  );

  modport slave (
    input  id_ex_selalushift, id_ex_selimregb, id_ex_selsarega, id_ex_aluop,
           id_ex_unsig, id_ex_shiftop, id_ex_shiftamt, id_ex_mdop, id_ex_rega,
           id_ex_regb, id_ex_imedext, id_ex_proximopc, id_ex_msm, id_ex_msl,
           id_ex_readmem, id_ex_writemem, id_ex_mshw, id_ex_lshw,
           id_ex_selwsource, id_ex_regdest, id_ex_writereg, id_ex_writeov,
    output ex_if_stall, ex_fw_wbvalue, ex_fw_writereg, ex_mem_msm, ex_mem_msl,
           ex_mem_readmem, ex_mem_writemem, ex_mem_mshw, ex_mem_lshw,
           ex_mem_regb, ex_mem_selwsource, ex_mem_regdest, ex_mem_writereg,
           ex_mem_aluout, ex_mem_wbvalue, ex_mem_ovf
  );

endinterface

`default_nettype wire

// File: rtl/muldiv_unit.sv
// ----------------------------------------------------------------------
// muldiv_unit : radix-2 shift-add multiply / restoring divide, HI/LO  rev 1.0
// ----------------------------------------------------------------------
`default_nettype none

module muldiv_unit
  import exec_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  wire logic              clock,
  input  wire logic              reset,
  input  wire logic              i_start,
  input  wire logic [2:0]        i_op,
  input  wire logic              i_unsig,
  input  wire logic [DATA_W-1:0] i_a,
  input  wire logic [DATA_W-1:0] i_b,
  output logic                   o_busy,
  output logic                   o_done,
  output logic [DATA_W-1:0]      o_hi,
  output logic [DATA_W-1:0]      o_lo
);
  localparam int CNT_W = $clog2(DATA_W);

  md_state_t           r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_isdiv, r_negq, r_negr, r_dz;
  logic [DATA_W-1:0]   r_acc, r_q, r_m, r_hi, r_lo;

  logic                w_sa, w_sb, w_fit;
  logic [DATA_W-1:0]   w_ma, w_mb, w_rem_sh, w_trial;
  logic [DATA_W:0]     w_sum;
  logic [DATA_W-1:0]   w_mul_acc, w_mul_q, w_div_acc, w_div_q;
  logic [DATA_W-1:0]   w_quo, w_rem, w_hi_fin, w_lo_fin;
  logic [2*DATA_W-1:0] w_prod, w_prod_s;

  // Iteration runs on magnitudes; signs are reapplied once at the end.
  assign w_sa = ~i_unsig & i_a[DATA_W-1];
  assign w_sb = ~i_unsig & i_b[DATA_W-1];
  assign w_ma = w_sa ? -i_a : i_a;
  assign w_mb = w_sb ? -i_b : i_b;

  assign w_sum     = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_m} : '0);
  assign w_mul_acc = w_sum[DATA_W:1];
  assign w_mul_q   = {w_sum[0], r_q[DATA_W-1:1]};

  // Partial remainder's dropped MSB means it already exceeds the divisor.
  assign w_rem_sh  = {r_acc[DATA_W-2:0], r_q[DATA_W-1]};
  assign w_fit     = r_acc[DATA_W-1] | (w_rem_sh >= r_m);
  assign w_trial   = w_rem_sh - r_m;
  assign w_div_acc = w_fit ? w_trial : w_rem_sh;
  assign w_div_q   = {r_q[DATA_W-2:0], w_fit};

  assign w_prod   = {w_mul_acc, w_mul_q};
  assign w_prod_s = r_negq ? -w_prod : w_prod;
  assign w_quo    = r_dz ? '1 : (r_negq ? -w_div_q : w_div_q);
  assign w_rem    = r_negr ? -w_div_acc : w_div_acc;
  assign w_hi_fin = r_isdiv ? w_rem : w_prod_s[2*DATA_W-1:DATA_W];
  assign w_lo_fin = r_isdiv ? w_quo : w_prod_s[DATA_W-1:0];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_isdiv <= 1'b0;
      r_negq  <= 1'b0;
      r_negr  <= 1'b0;
      r_dz    <= 1'b0;
      r_acc   <= '0;
      r_q     <= '0;
      r_m     <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_state <= BUSY;
            r_cnt   <= CNT_W'(DATA_W - 1);
            r_isdiv <= (i_op == c_md_div);
            r_negq  <= w_sa ^ w_sb;
            r_negr  <= w_sa;
            r_dz    <= (i_b == '0);
            r_acc   <= '0;
            r_q     <= w_ma;
            r_m     <= w_mb;
          end else if (i_op == c_md_mthi) begin
            r_hi <= i_a;
          end else if (i_op == c_md_mtlo) begin
            r_lo <= i_a;
          end
        end
        BUSY: begin
          r_acc <= r_isdiv ? w_div_acc : w_mul_acc;
          r_q   <= r_isdiv ? w_div_q : w_mul_q;
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == '0) begin
            r_state <= DONE;
            r_hi    <= w_hi_fin;
            r_lo    <= w_lo_fin;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Gated by reset so the stall drops the instant reset asserts.
  assign o_busy = reset & (((r_state == IDLE) & i_start) | (r_state == BUSY));
  assign o_done = (r_state == DONE);
  assign o_hi   = r_hi;
  assign o_lo   = r_lo;

endmodule

`default_nettype wire

// File: rtl/execute_md.sv
// ----------------------------------------------------------------------
// execute_md : EX stage (ALU, shifter, mul/div) owning EX/MEM   rev 1.0
// ----------------------------------------------------------------------
`default_nettype none

module execute_md
  import exec_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int SHAMT_W = 5,
  parameter int REG_W   = 5
) (
  input  wire logic   clock,
  input  wire logic   reset,
  execute_md_if.slave bus
);
  logic [DATA_W-1:0]  w_opa, w_opb, w_sum, w_diff, w_alu, w_sh;
  logic [DATA_W-1:0]  w_aluout, w_wbvalue, w_hi, w_lo;
  logic [SHAMT_W-1:0] w_amt, w_rot_l;
  logic [REG_W-1:0]   w_regdest;
  logic               w_lt, w_ovf, w_start, w_stall, w_done, w_wr;

  assign w_opa     = bus.id_ex_rega;
  assign w_opb     = bus.id_ex_selimregb ? bus.id_ex_imedext : bus.id_ex_regb;
  assign w_sum     = w_opa + w_opb;
  assign w_diff    = w_opa - w_opb;
  assign w_lt      = bus.id_ex_unsig ? (w_opa < w_opb) : ($signed(w_opa) < $signed(w_opb));
  assign w_regdest = bus.id_ex_regdest;

  assign w_ovf = ~bus.id_ex_unsig &
                 (((bus.id_ex_aluop == c_alu_add) & (w_opa[DATA_W-1] == w_opb[DATA_W-1]) &
                   (w_sum[DATA_W-1] != w_opa[DATA_W-1])) |
                  ((bus.id_ex_aluop == c_alu_sub) & (w_opa[DATA_W-1] != w_opb[DATA_W-1]) &
                   (w_diff[DATA_W-1] != w_opa[DATA_W-1])));

  always_comb begin
    w_alu = '0;
    case (bus.id_ex_aluop)
      c_alu_and:   w_alu = w_opa & w_opb;
      c_alu_or:    w_alu = w_opa | w_opb;
      c_alu_add:   w_alu = w_sum;
      c_alu_xor:   w_alu = w_opa ^ w_opb;
      c_alu_nor:   w_alu = ~(w_opa | w_opb);
      c_alu_passb: w_alu = w_opb;
      c_alu_sub:   w_alu = w_diff;
      c_alu_slt:   w_alu = {{(DATA_W-1){1'b0}}, w_lt};
    endcase
  end

  assign w_amt   = bus.id_ex_selsarega ? bus.id_ex_rega[SHAMT_W-1:0] : bus.id_ex_shiftamt;
  // Left part of a rotate; wraps to 0 for a zero amount, which is harmless.
  assign w_rot_l = -w_amt;

  always_comb begin
    w_sh = bus.id_ex_regb;
    case (bus.id_ex_shiftop)
      c_sh_srl: w_sh = bus.id_ex_regb >> w_amt;
      c_sh_sra: w_sh = $signed(bus.id_ex_regb) >>> w_amt;
      c_sh_sll: w_sh = bus.id_ex_regb << w_amt;
      default:  w_sh = (bus.id_ex_regb >> w_amt) | (bus.id_ex_regb << w_rot_l);
    endcase
  end

  assign w_aluout = bus.id_ex_selalushift ? w_sh : w_alu;

  always_comb begin
    w_wbvalue = w_aluout;
    case (bus.id_ex_selwsource)
      c_wb_alu:  w_wbvalue = w_aluout;
      c_wb_pc:   w_wbvalue = bus.id_ex_proximopc;
      c_wb_hilo: w_wbvalue = (bus.id_ex_mdop == c_md_mfhi) ? w_hi : w_lo;
      c_wb_imm:  w_wbvalue = bus.id_ex_imedext;
      default:   w_wbvalue = w_aluout;
    endcase
  end

  assign w_start = is_muldiv(bus.id_ex_mdop);

  muldiv_unit #(
    .DATA_W (DATA_W)
  ) u_muldiv (
    .clock   (clock),
    .reset   (reset),
    .i_start (w_start),
    .i_op    (bus.id_ex_mdop),
    .i_unsig (bus.id_ex_unsig),
    .i_a     (bus.id_ex_rega),
    .i_b     (bus.id_ex_regb),
    .o_busy  (w_stall),
    .o_done  (w_done),
    .o_hi    (w_hi),
    .o_lo    (w_lo)
  );

  // The finishing mul/div leaves EX with no register write of its own.
  assign w_wr = bus.id_ex_writereg & ~(bus.id_ex_writeov & w_ovf) & ~w_stall & ~w_done;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bus.ex_mem_msm        <= '0;
      bus.ex_mem_msl        <= '0;
      bus.ex_mem_readmem    <= 1'b0;
      bus.ex_mem_writemem   <= 1'b0;
      bus.ex_mem_mshw       <= 1'b0;
      bus.ex_mem_lshw       <= 1'b0;
      bus.ex_mem_regb       <= '0;
      bus.ex_mem_selwsource <= '0;
      bus.ex_mem_regdest    <= '0;
      bus.ex_mem_writereg   <= 1'b0;
      bus.ex_mem_aluout     <= '0;
      bus.ex_mem_wbvalue    <= '0;
      bus.ex_mem_ovf        <= 1'b0;
    end else begin
      bus.ex_mem_msm        <= bus.id_ex_msm;
      bus.ex_mem_msl        <= bus.id_ex_msl;
      bus.ex_mem_readmem    <= bus.id_ex_readmem & ~w_stall;
      bus.ex_mem_writemem   <= bus.id_ex_writemem & ~w_stall;
      bus.ex_mem_mshw       <= bus.id_ex_mshw;
      bus.ex_mem_lshw       <= bus.id_ex_lshw;
      bus.ex_mem_regb       <= bus.id_ex_regb;
      bus.ex_mem_selwsource <= bus.id_ex_selwsource;
      bus.ex_mem_regdest    <= w_regdest;
      bus.ex_mem_writereg   <= w_wr;
      bus.ex_mem_aluout     <= w_aluout;
      bus.ex_mem_wbvalue    <= w_wbvalue;
      bus.ex_mem_ovf        <= w_ovf;
    end
  end

  assign bus.ex_if_stall    = w_stall;
  assign bus.ex_fw_wbvalue  = bus.ex_mem_wbvalue;
  assign bus.ex_fw_writereg = bus.ex_mem_writereg;

endmodule

`default_nettype wire

// File: tb/tb_execute_md.sv
// ----------------------------------------------------------------------
// tb_execute_md : directed + random checks of the execute_md EX stage  rev 1.0
// ----------------------------------------------------------------------
`default_nettype none

module tb_execute_md;
  import exec_pkg::*;

  localparam int DW = 32;
  localparam int SW = 5;
  localparam int RW = 5;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;

  execute_md_if #(.DATA_W(DW), .SHAMT_W(SW), .REG_W(RW)) bus ();

  execute_md #(.DATA_W(DW), .SHAMT_W(SW), .REG_W(RW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    bus.id_ex_selalushift = 0; bus.id_ex_selimregb = 0; bus.id_ex_selsarega = 0;
    bus.id_ex_aluop = 0; bus.id_ex_unsig = 0; bus.id_ex_shiftop = 0;
    bus.id_ex_shiftamt = 0; bus.id_ex_mdop = c_md_none; bus.id_ex_rega = 0;
    bus.id_ex_regb = 0; bus.id_ex_imedext = 0; bus.id_ex_proximopc = 0;
    bus.id_ex_msm = 0; bus.id_ex_msl = 0; bus.id_ex_readmem = 0;
    bus.id_ex_writemem = 0; bus.id_ex_mshw = 0; bus.id_ex_lshw = 0;
    bus.id_ex_selwsource = 0; bus.id_ex_regdest = 0; bus.id_ex_writereg = 0;
    bus.id_ex_writeov = 0;
  endtask

  function automatic logic [DW-1:0] m_shift(input logic [1:0] op, input logic [DW-1:0] v,
                                            input int n);
    logic [DW-1:0] r;
    r = v;
    case (op)
      2'd0: r = v >> n;
      2'd1: r = $signed(v) >>> n;
      2'd2: r = v << n;
      default: for (int i = 0; i < n; i++) r = {r[0], r[DW-1:1]};
    endcase
    return r;
  endfunction

  task automatic m_alu(input logic [2:0] op, input logic uns, input logic [DW-1:0] a,
                       input logic [DW-1:0] b, output logic [DW-1:0] r, output logic ovf);
    longint sa, sb, s;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    s = 0;
    ovf = 1'b0;
    r = '0;
    case (op)
      3'd0: r = a & b;
      3'd1: r = a | b;
      3'd2: begin r = a + b; s = sa + sb; ovf = !uns && (s > 64'sd2147483647 || s < -64'sd2147483648); end
      3'd3: r = a ^ b;
      3'd4: r = ~(a | b);
      3'd5: r = b;
      3'd6: begin r = a - b; s = sa - sb; ovf = !uns && (s > 64'sd2147483647 || s < -64'sd2147483648); end
      default: r = (uns ? (a < b) : (sa < sb)) ? 32'd1 : 32'd0;
    endcase
  endtask

  task automatic m_muldiv(input logic [2:0] op, input logic uns, input logic [DW-1:0] a,
                          input logic [DW-1:0] b, output logic [DW-1:0] hi, output logic [DW-1:0] lo);
    longint p, q, r;
    if (op == c_md_mult) begin
      if (uns) p = longint'({32'b0, a} * {32'b0, b});
      else     p = longint'($signed(a)) * longint'($signed(b));
      hi = p[63:32];
      lo = p[31:0];
    end else if (b == 0) begin
      hi = a;
      lo = '1;
    end else if (uns) begin
      hi = a % b;
      lo = a / b;
    end else begin
      q = longint'($signed(a)) / longint'($signed(b));
      r = longint'($signed(a)) % longint'($signed(b));
      hi = r[31:0];
      lo = q[31:0];
    end
  endtask

  task automatic run_md(input string tag, input logic [2:0] op, input logic uns,
                        input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic [DW-1:0] exp_hi, input logic [DW-1:0] exp_lo);
    int cyc;
    cyc = 0;
    clear_inputs();
    bus.id_ex_mdop = op; bus.id_ex_unsig = uns; bus.id_ex_rega = a; bus.id_ex_regb = b;
    bus.id_ex_writereg = 1; bus.id_ex_readmem = 1; bus.id_ex_writemem = 1;
    #1;
    while (bus.ex_if_stall === 1'b1 && cyc < 100) begin
      cyc++;
      tick();
      check({tag, " bubble"}, {bus.ex_mem_writereg, bus.ex_mem_readmem, bus.ex_mem_writemem}, 0);
    end
    check({tag, " stall cycles"}, cyc, DW + 1);
    tick();
    check({tag, " done writereg"}, bus.ex_mem_writereg, 0);
    clear_inputs();
    bus.id_ex_mdop = c_md_mflo; bus.id_ex_selwsource = c_wb_hilo; bus.id_ex_writereg = 1;
    tick();
    check({tag, " LO"}, bus.ex_mem_wbvalue, exp_lo);
    check({tag, " MFLO writereg"}, bus.ex_mem_writereg, 1);
    bus.id_ex_mdop = c_md_mfhi;
    tick();
    check({tag, " HI"}, bus.ex_mem_wbvalue, exp_hi);
  endtask

  initial begin
    logic [DW-1:0] e_r, e_wb, e_hi, e_lo;
    logic          e_ov;
    logic [2:0]    op;
    logic          uns;
    logic [DW-1:0] a, b;

    clear_inputs();
    #3 reset = 0;
    #1;
    check("reset stall", bus.ex_if_stall, 0);
    check("reset aluout/wb", {bus.ex_mem_aluout, bus.ex_mem_wbvalue}, 0);
    check("reset ctrl", {bus.ex_mem_msm, bus.ex_mem_msl, bus.ex_mem_readmem, bus.ex_mem_writemem,
                         bus.ex_mem_mshw, bus.ex_mem_lshw, bus.ex_mem_selwsource,
                         bus.ex_mem_regdest, bus.ex_mem_writereg, bus.ex_mem_ovf}, 0);
    check("reset regb", bus.ex_mem_regb, 0);
    @(negedge clock) reset = 1;

    clear_inputs();
    bus.id_ex_aluop = c_alu_add; bus.id_ex_rega = 1; bus.id_ex_regb = 5; bus.id_ex_writereg = 1;
    bus.id_ex_msm = 3'd5; bus.id_ex_regdest = 5'd17; bus.id_ex_mshw = 1;
    tick();
    check("add aluout", bus.ex_mem_aluout, 6);
    check("add wbvalue", bus.ex_mem_wbvalue, 6);
    check("add fw value", bus.ex_fw_wbvalue, 6);
    check("add fw writereg", bus.ex_fw_writereg, 1);
    check("add stall", bus.ex_if_stall, 0);
    check("passthrough", {bus.ex_mem_msm, bus.ex_mem_regdest, bus.ex_mem_mshw, bus.ex_mem_regb},
          {3'd5, 5'd17, 1'b1, 32'd5});

    clear_inputs();
    bus.id_ex_selalushift = 1; bus.id_ex_shiftop = c_sh_sll; bus.id_ex_shiftamt = 1; bus.id_ex_regb = 5;
    tick();
    check("sll imm", bus.ex_mem_aluout, 10);
    bus.id_ex_selsarega = 1; bus.id_ex_rega = 4;
    tick();
    check("sll rega", bus.ex_mem_aluout, 80);

    clear_inputs();
    bus.id_ex_aluop = c_alu_add; bus.id_ex_rega = 32'h7FFF_FFFF; bus.id_ex_regb = 1;
    bus.id_ex_writereg = 1; bus.id_ex_writeov = 1;
    tick();
    check("ovf writeov=1 flag", bus.ex_mem_ovf, 1);
    check("ovf writeov=1 writereg", bus.ex_mem_writereg, 0);
    bus.id_ex_writeov = 0;
    tick();
    check("ovf writeov=0 flag", bus.ex_mem_ovf, 1);
    check("ovf writeov=0 writereg", bus.ex_mem_writereg, 1);

    for (int k = 0; k < 24; k++) begin
      clear_inputs();
      bus.id_ex_aluop = 3'($urandom_range(0, 7));
      bus.id_ex_unsig = 1'($urandom_range(0, 1));
      bus.id_ex_selimregb = 1'($urandom_range(0, 1));
      bus.id_ex_selalushift = 1'($urandom_range(0, 1));
      bus.id_ex_selsarega = 1'($urandom_range(0, 1));
      bus.id_ex_shiftop = 2'($urandom_range(0, 3));
      bus.id_ex_shiftamt = 5'($urandom_range(0, 31));
      bus.id_ex_rega = (k % 4 == 0) ? 32'h8000_0000 : $urandom;
      bus.id_ex_regb = (k % 6 == 0) ? 32'h7FFF_FFFF : $urandom;
      bus.id_ex_imedext = $urandom;
      bus.id_ex_proximopc = $urandom;
      bus.id_ex_selwsource = 3'($urandom_range(0, 7));
      if (bus.id_ex_selwsource == c_wb_hilo) bus.id_ex_selwsource = c_wb_alu;
      bus.id_ex_writereg = 1;
      bus.id_ex_writeov = 1'($urandom_range(0, 1));
      m_alu(bus.id_ex_aluop, bus.id_ex_unsig, bus.id_ex_rega,
            bus.id_ex_selimregb ? bus.id_ex_imedext : bus.id_ex_regb, e_r, e_ov);
      if (bus.id_ex_selalushift)
        e_r = m_shift(bus.id_ex_shiftop, bus.id_ex_regb,
                      bus.id_ex_selsarega ? int'(bus.id_ex_rega[4:0]) : int'(bus.id_ex_shiftamt));
      e_wb = (bus.id_ex_selwsource == c_wb_pc)  ? bus.id_ex_proximopc :
             (bus.id_ex_selwsource == c_wb_imm) ? bus.id_ex_imedext : e_r;
      tick();
      check($sformatf("rand%0d aluout", k), bus.ex_mem_aluout, e_r);
      check($sformatf("rand%0d wbvalue", k), bus.ex_mem_wbvalue, e_wb);
      check($sformatf("rand%0d ovf", k), bus.ex_mem_ovf, e_ov);
      check($sformatf("rand%0d writereg", k), bus.ex_mem_writereg, !(bus.id_ex_writeov && e_ov));
    end

    run_md("mult -3x7", c_md_mult, 0, -32'sd3, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run_md("div -7/2", c_md_div, 0, -32'sd7, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_md("div 7/0", c_md_div, 0, 32'd7, 32'd0, 32'd7, 32'hFFFF_FFFF);

    clear_inputs();
    bus.id_ex_mdop = c_md_mthi; bus.id_ex_rega = 32'h1234_5678;
    tick();
    bus.id_ex_mdop = c_md_mtlo; bus.id_ex_rega = 32'h9ABC_DEF0;
    tick();
    clear_inputs();
    bus.id_ex_mdop = c_md_mfhi; bus.id_ex_selwsource = c_wb_hilo;
    tick();
    check("mthi", bus.ex_mem_wbvalue, 32'h1234_5678);
    bus.id_ex_mdop = c_md_mflo;
    tick();
    check("mtlo", bus.ex_mem_wbvalue, 32'h9ABC_DEF0);

    for (int k = 0; k < 6; k++) begin
      op  = (k % 2 == 0) ? c_md_mult : c_md_div;
      uns = 1'($urandom_range(0, 1));
      a   = $urandom;
      b   = (k == 5) ? 32'd0 : ((k % 3 == 1) ? 32'($urandom_range(1, 9)) : $urandom);
      if (k == 3) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      m_muldiv(op, uns, a, b, e_hi, e_lo);
      run_md($sformatf("rand md%0d", k), op, uns, a, b, e_hi, e_lo);
    end

    clear_inputs();
    bus.id_ex_mdop = c_md_div; bus.id_ex_rega = 32'd100; bus.id_ex_regb = 32'd3;
    #1;
    for (int i = 0; i < 10; i++) tick();
    check("pre-reset stall", bus.ex_if_stall, 1);
    #2 reset = 0;
    #1;
    check("abort stall", bus.ex_if_stall, 0);
    check("abort ex_mem", {bus.ex_mem_aluout, bus.ex_mem_writereg, bus.ex_mem_regb}, 0);
    clear_inputs();
    @(negedge clock) reset = 1;
    bus.id_ex_mdop = c_md_mflo; bus.id_ex_selwsource = c_wb_hilo;
    tick();
    check("abort LO", bus.ex_mem_wbvalue, 0);
    bus.id_ex_mdop = c_md_mfhi;
    tick();
    check("abort HI", bus.ex_mem_wbvalue, 0);
    run_md("mult after abort", c_md_mult, 0, 32'd5, 32'd6, 32'd0, 32'd30);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
